aes_dec_dma: RTL and testbench

Wishbone block-move engine that sits directly upstream of the AES decryption Wishbone slave. It reads 128-bit ciphertext blocks from system memory, writes each block into the decryptor's four cipher-input registers, polls the decrypt-done register, reads back the four plaintext words and writes them to a destination buffer. It is a dual-master sequencer: one classic Wishbone master toward memory and one toward the decryptor's 8-bit register map, driven by a simple start/length/address control interface.

---
 rtl/aes_dec_dma_if.sv | 14 +
 rtl/aes_dec_dma.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_dec_dma.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_dma_if.sv
// Classic single-beat Wishbone link shared by the memory master and the AES engine master.
interface aes_dec_dma_if #(parameter int AW = 32);
  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i;
  logic [3:0]    sel_o;
  logic          we_o;
  logic          cyc_o;
  logic          stb_o;
  logic          ack_i;

  modport master (output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, input dat_i, ack_i);
  modport slave  (input adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, output dat_i, ack_i);
endinterface

// File: rtl/aes_dec_dma.sv
// Block-move sequencer: memory -> AES decrypt engine registers -> poll -> plaintext -> memory.
// One registered FSM drives both Wishbone masters; all bus outputs come straight from flops.
module aes_dec_dma #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [CNT_W-1:0] num_blk_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  aes_dec_dma_if.master    m,
  aes_dec_dma_if.master    e
);
  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, M_RD, E_WR, GAP, POLL_REQ, POLL_DAT, E_RD_REQ, E_RD_DAT, M_WR, NEXT
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src, r_dst;
  logic [CNT_W-1:0] r_numBlk, r_blkCnt;
  logic [PW-1:0]    r_pollCnt;
  logic [GW-1:0]    r_gapCnt;
  logic [1:0]       r_wordIdx;
  logic [31:0]      r_buf [4];
  logic             r_busy, r_done, r_err;
  logic [31:0]      r_mAdr, r_mDat;
  logic             r_mCyc, r_mWe;
  logic [7:0]       r_eAdr;
  logic [31:0]      r_eDat;
  logic             r_eCyc, r_eWe;

  logic [1:0]       w_nextIdx;
  logic [CNT_W-1:0] w_blkInc;

  assign w_nextIdx = r_wordIdx + 2'd1;
  assign w_blkInc  = r_blkCnt + 1'b1;

  // r_wordIdx walks 0..3 in every phase and wraps to 0, which marks the phase as finished.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_numBlk  <= '0;
      r_blkCnt  <= '0;
      r_pollCnt <= '0;
      r_gapCnt  <= '0;
      r_wordIdx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mAdr    <= '0;
      r_mDat    <= '0;
      r_mCyc    <= 1'b0;
      r_mWe     <= 1'b0;
      r_eAdr    <= '0;
      r_eDat    <= '0;
      r_eCyc    <= 1'b0;
      r_eWe     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i && !r_done) begin
            r_src     <= src_adr_i;
            r_dst     <= dst_adr_i;
            r_numBlk  <= num_blk_i;
            r_err     <= 1'b0;
            r_blkCnt  <= '0;
            r_pollCnt <= '0;
            r_wordIdx <= '0;
            if (num_blk_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= M_RD;
              r_mCyc  <= 1'b1;
              r_mWe   <= 1'b0;
              r_mAdr  <= src_adr_i;
            end
          end
        end
        M_RD: begin
          if (r_mCyc) begin
            if (m.ack_i) begin
              r_buf[r_wordIdx] <= m.dat_i;
              r_mCyc           <= 1'b0;
              r_wordIdx        <= w_nextIdx;
            end
          end else if (r_wordIdx == 2'd0) begin
            r_state <= E_WR;
            r_eCyc  <= 1'b1;
            r_eWe   <= 1'b1;
            r_eAdr  <= 8'h00;
            r_eDat  <= r_buf[0];
          end else begin
            r_mCyc <= 1'b1;
            r_mAdr <= r_src + {28'd0, r_wordIdx, 2'b00};
          end
        end
        E_WR: begin
          if (e.ack_i) begin
            r_wordIdx <= w_nextIdx;
            if (r_wordIdx == 2'd3) begin
              r_eCyc   <= 1'b0;
              r_eWe    <= 1'b0;
              r_gapCnt <= '0;
              r_state  <= GAP;
            end else begin
              r_eAdr <= {4'h0, w_nextIdx, 2'b00};
              r_eDat <= r_buf[w_nextIdx];
            end
          end
        end
        GAP: begin
          if (r_gapCnt == GW'(GAP_CYCLES - 1)) begin
            r_state <= POLL_REQ;
            r_eCyc  <= 1'b1;
            r_eAdr  <= 8'h20;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        POLL_REQ: begin
          if (e.ack_i) begin
            r_eCyc  <= 1'b0;
            r_state <= POLL_DAT;
          end
        end
        POLL_DAT: begin
          if (e.dat_i[0]) begin
            r_state <= E_RD_REQ;
            r_eCyc  <= 1'b1;
            r_eAdr  <= 8'h10;
          end else if (r_pollCnt == PW'(POLL_TIMEOUT - 1)) begin
            r_pollCnt <= r_pollCnt + 1'b1;
            r_err     <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_pollCnt <= r_pollCnt + 1'b1;
            r_eCyc    <= 1'b1;
            r_state   <= POLL_REQ;
          end
        end
        E_RD_REQ: begin
          if (e.ack_i) begin
            r_eCyc  <= 1'b0;
            r_state <= E_RD_DAT;
          end
        end
        E_RD_DAT: begin
          r_buf[r_wordIdx] <= e.dat_i;
          r_wordIdx        <= w_nextIdx;
          if (r_wordIdx == 2'd3) begin
            r_state <= M_WR;
            r_mCyc  <= 1'b1;
            r_mWe   <= 1'b1;
            r_mAdr  <= r_dst;
            r_mDat  <= r_buf[0];
          end else begin
            r_state <= E_RD_REQ;
            r_eCyc  <= 1'b1;
            r_eAdr  <= {4'h1, w_nextIdx, 2'b00};
          end
        end
        M_WR: begin
          if (r_mCyc) begin
            if (m.ack_i) begin
              r_mCyc    <= 1'b0;
              r_mWe     <= 1'b0;
              r_wordIdx <= w_nextIdx;
            end
          end else if (r_wordIdx == 2'd0) begin
            r_state <= NEXT;
          end else begin
            r_mCyc <= 1'b1;
            r_mWe  <= 1'b1;
            r_mAdr <= r_dst + {28'd0, r_wordIdx, 2'b00};
            r_mDat <= r_buf[r_wordIdx];
          end
        end
        NEXT: begin
          r_blkCnt  <= w_blkInc;
          r_src     <= r_src + 32'd16;
          r_dst     <= r_dst + 32'd16;
          r_pollCnt <= '0;
          if (w_blkInc == r_numBlk) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= M_RD;
            r_mCyc  <= 1'b1;
            r_mWe   <= 1'b0;
            r_mAdr  <= r_src + 32'd16;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m.adr_o = r_mAdr;
  assign m.dat_o = r_mDat;
  assign m.sel_o = 4'hf;
  assign m.we_o  = r_mWe;
  assign m.cyc_o = r_mCyc;
  assign m.stb_o = r_mCyc;

  assign e.adr_o = r_eAdr;
  assign e.dat_o = r_eDat;
  assign e.sel_o = 4'hf;
  assign e.we_o  = r_eWe;
  assign e.cyc_o = r_eCyc;
  assign e.stb_o = r_eCyc;

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign blk_cnt_o = r_blkCnt;
endmodule

// File: tb/tb_aes_dec_dma.sv
// Bench for aes_dec_dma: word-array memory slave with programmable ack delay, AES engine stub
// whose "decryption" is word reversal XOR a constant, and a block-level reference model.
module tb_aes_dec_dma;
  localparam int TO  = 8;
  localparam int GAP = 4;
  localparam int CW  = 16;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startIn = 1'b0;
  logic [31:0] srcAdr = '0;
  logic [31:0] dstAdr = '0;
  logic [CW-1:0] numBlk = '0;
  logic busy, done, err;
  logic [CW-1:0] blkCnt;

  int compareCount = 0;
  int mismatchCount = 0;

  aes_dec_dma_if #(.AW(32)) memBus();
  aes_dec_dma_if #(.AW(8))  engBus();

  aes_dec_dma #(.POLL_TIMEOUT(TO), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(startIn),
    .src_adr_i(srcAdr), .dst_adr_i(dstAdr), .num_blk_i(numBlk),
    .busy_o(busy), .done_o(done), .err_o(err), .blk_cnt_o(blkCnt),
    .m(memBus), .e(engBus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int memDelay = 0;
  int memWait = 0;
  int memCycCnt = 0;
  int engCycCnt = 0;
  int protoErr = 0;
  logic prevMemAck = 1'b0;
  logic prevMemHold = 1'b0;
  logic [31:0] wrAdrLog [$];
  logic [31:0] wrDatLog [$];
  logic [31:0] rdAdrLog [$];

  assign memBus.ack_i = memBus.cyc_o && memBus.stb_o && (memWait >= memDelay);
  assign memBus.dat_i = mem[memBus.adr_o[11:2]];

  // Memory slave: logs every completed beat and flags Wishbone handshake violations.
  always @(posedge clk) begin
    if (memBus.cyc_o && memBus.stb_o && !memBus.ack_i) memWait <= memWait + 1;
    else memWait <= 0;
    if (memBus.ack_i) begin
      if (memBus.we_o) begin
        wrAdrLog.push_back(memBus.adr_o);
        wrDatLog.push_back(memBus.dat_o);
      end else begin
        rdAdrLog.push_back(memBus.adr_o);
      end
    end
    if (memBus.cyc_o) memCycCnt <= memCycCnt + 1;
    if (engBus.cyc_o) engCycCnt <= engCycCnt + 1;
    if (!rst && ((memBus.stb_o != memBus.cyc_o) || (engBus.stb_o != engBus.cyc_o) ||
                 (memBus.cyc_o && memBus.sel_o != 4'hf) || (engBus.cyc_o && engBus.sel_o != 4'hf) ||
                 (prevMemAck && memBus.cyc_o) || (prevMemHold && !memBus.cyc_o)))
      protoErr <= protoErr + 1;
    prevMemAck  <= !rst && memBus.ack_i;
    prevMemHold <= !rst && memBus.cyc_o && !memBus.ack_i;
  end

  logic [31:0] cipher [0:3];
  logic [31:0] engRd = '0;
  int donePolls = 1;
  int pollsSeen = 0;
  int pollTotal = 0;
  logic [7:0] engWrLog [$];

  assign engBus.ack_i = engBus.cyc_o && engBus.stb_o;
  assign engBus.dat_i = engRd;

  // Engine stub: donePolls==0 means the done bit never rises; otherwise the Nth poll sees it.
  always @(posedge clk) begin
    if (engBus.ack_i) begin
      if (engBus.we_o) begin
        engWrLog.push_back(engBus.adr_o);
        if (engBus.adr_o < 8'h10) cipher[engBus.adr_o[3:2]] <= engBus.dat_o;
        if (engBus.adr_o == 8'h0c) pollsSeen <= 0;
      end else if (engBus.adr_o == 8'h20) begin
        pollTotal <= pollTotal + 1;
        pollsSeen <= pollsSeen + 1;
        engRd <= {31'd0, (donePolls != 0) && (pollsSeen + 1 >= donePolls)};
      end else if (engBus.adr_o[7:4] == 4'h1) begin
        engRd <= cipher[~engBus.adr_o[3:2]] ^ KEY;
      end else begin
        engRd <= 32'hBAD0_0000;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic fillSrc(input logic [31:0] src, input int nWords);
    for (int k = 0; k < nWords; k++) mem[int'(src[11:2]) + k] = $urandom;
  endtask

  // Runs one transfer and checks it against the block-level model of the expected bus traffic.
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int nblk,
                               input int polls, input int delay, input bit restart, input bit expectTo);
    int rd0, wr0, ew0, poll0, proto0;
    int cycles, doneAt, extraDone, blocksRun, expLat, srcIdx;
    logic [31:0] expWord;
    rd0 = rdAdrLog.size(); wr0 = wrAdrLog.size(); ew0 = engWrLog.size();
    poll0 = pollTotal; proto0 = protoErr;
    srcIdx = int'(src[11:2]);
    donePolls = expectTo ? 0 : polls;
    memDelay = delay;
    @(negedge clk);
    srcAdr = src; dstAdr = dst; numBlk = CW'(nblk); startIn = 1'b1;
    cycles = 0; doneAt = 0; extraDone = 0;
    while (doneAt == 0 && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      startIn = restart && (cycles == 10);
      if (startIn) begin
        srcAdr = src + 32'h40; dstAdr = dst + 32'h40; numBlk = CW'(1);
      end
      if (cycles == 2) checkOutput("busyDuring", busy, 1);
      if (done) doneAt = cycles;
    end
    repeat (4) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    blocksRun = expectTo ? 1 : nblk;
    expLat = expectTo ? (4*delay + 8 + 4 + GAP + 2*TO + 1)
                      : nblk * (4*delay + 8 + 4 + GAP + 2*polls + 8 + 4*delay + 8 + 1) + 1;
    checkOutput("doneLatency", doneAt, expLat);
    checkOutput("extraDone", extraDone, 0);
    checkOutput("busyAfter", busy, 0);
    checkOutput("errFlag", err, expectTo);
    checkOutput("blkCnt", blkCnt, expectTo ? 0 : nblk);
    checkOutput("pollCount", pollTotal - poll0, expectTo ? TO : nblk * polls);
    checkOutput("protocol", protoErr - proto0, 0);
    checkOutput("memReads", rdAdrLog.size() - rd0, 4 * blocksRun);
    for (int k = 0; k < 4 * blocksRun && rd0 + k < rdAdrLog.size(); k++)
      checkOutput("memRdAdr", rdAdrLog[rd0 + k], src + 32'(4 * k));
    checkOutput("engWrites", engWrLog.size() - ew0, 4 * blocksRun);
    for (int k = 0; k < 4 * blocksRun && ew0 + k < engWrLog.size(); k++)
      checkOutput("engWrAdr", engWrLog[ew0 + k], 32'(4 * (k % 4)));
    checkOutput("memWrites", wrAdrLog.size() - wr0, expectTo ? 0 : 4 * nblk);
    for (int k = 0; k < (expectTo ? 0 : 4 * nblk) && wr0 + k < wrAdrLog.size(); k++) begin
      expWord = mem[srcIdx + 4 * (k / 4) + (3 - k % 4)] ^ KEY;
      checkOutput("memWrAdr", wrAdrLog[wr0 + k], dst + 32'(4 * k));
      checkOutput("memWrDat", wrDatLog[wr0 + k], expWord);
    end
  endtask

  initial begin
    int mc0, ec0, guard, n, p, d;
    logic [31:0] s, t;
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;

    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstBlkCnt", blkCnt, 0);
    checkOutput("rstMemCyc", memBus.cyc_o, 0);
    checkOutput("rstEngCyc", engBus.cyc_o, 0);
    checkOutput("rstMemAdr", memBus.adr_o, 0);
    rst = 1'b0;

    $display("[TB] single block, fixed pattern");
    mem[32'h100 >> 2]       = 32'h0011_2233;
    mem[(32'h100 >> 2) + 1] = 32'h4455_6677;
    mem[(32'h100 >> 2) + 2] = 32'h8899_AABB;
    mem[(32'h100 >> 2) + 3] = 32'hCCDD_EEFF;
    applyStimulus(32'h100, 32'h200, 1, 3, 0, 1'b0, 1'b0);

    $display("[TB] three blocks");
    fillSrc(32'h100, 12);
    applyStimulus(32'h100, 32'h200, 3, 2, 0, 1'b0, 1'b0);

    $display("[TB] poll timeout");
    fillSrc(32'h300, 4);
    applyStimulus(32'h300, 32'h600, 1, 0, 0, 1'b0, 1'b1);

    $display("[TB] zero blocks, start on done cycle");
    mc0 = memCycCnt; ec0 = engCycCnt;
    @(negedge clk);
    numBlk = '0; srcAdr = 32'h100; dstAdr = 32'h200; startIn = 1'b1;
    @(negedge clk);
    checkOutput("zeroDone", done, 1);
    checkOutput("zeroErrClr", err, 0);
    checkOutput("zeroBusy", busy, 0);
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    checkOutput("zeroIgnored", done, 0);
    repeat (3) @(negedge clk);
    checkOutput("zeroNoCyc", (memCycCnt - mc0) + (engCycCnt - ec0), 0);

    $display("[TB] delayed memory ack with re-pulsed start");
    fillSrc(32'h100, 8);
    applyStimulus(32'h100, 32'h200, 2, 2, 3, 1'b1, 1'b0);

    $display("[TB] reset during engine readback");
    fillSrc(32'h100, 8);
    donePolls = 1; memDelay = 0;
    @(negedge clk);
    srcAdr = 32'h100; dstAdr = 32'h200; numBlk = CW'(2); startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    guard = 0;
    while (!(engBus.cyc_o && !engBus.we_o && engBus.adr_o == 8'h14 && blkCnt == CW'(1)) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rstReachErd", guard < 2000, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstMemCyc", memBus.cyc_o, 0);
    checkOutput("midRstMemStb", memBus.stb_o, 0);
    checkOutput("midRstEngCyc", engBus.cyc_o, 0);
    checkOutput("midRstEngStb", engBus.stb_o, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstBlkCnt", blkCnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midRstIdle", busy | memBus.cyc_o | engBus.cyc_o, 0);

    $display("[TB] randomized transfers");
    for (int r = 0; r < 8; r++) begin
      s = 32'($urandom_range(0, 255)) << 2;
      t = 32'h800 + (32'($urandom_range(0, 255)) << 2);
      n = $urandom_range(1, 4);
      p = $urandom_range(1, 5);
      d = $urandom_range(0, 2);
      fillSrc(s, 4 * n);
      applyStimulus(s, t, n, p, d, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
